// File: rtl/io_map_pkg.sv
// IO address map and shared types for the memory/IO router and its IO-side responders.
package io_map_pkg;

    localparam int          IO_DATA_W   = 24;

    localparam logic [31:0] LED_LO_ADDR = 32'hFFFF_FC60;
    localparam logic [31:0] LED_HI_ADDR = 32'hFFFF_FC62;
    localparam logic [31:0] SW_LO_ADDR  = 32'hFFFF_FC70;
    localparam logic [31:0] SW_HI_ADDR  = 32'hFFFF_FC72;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_LED_LO,
        SEL_LED_HI,
        SEL_SW_LO,
        SEL_SW_HI
    } io_sel_e;

    // Full 32-bit compare; anything outside the map decodes to SEL_NONE.
    function automatic io_sel_e io_decode(input logic [31:0] addr);
        io_sel_e sel;
        case (addr)
            LED_LO_ADDR: sel = SEL_LED_LO;
            LED_HI_ADDR: sel = SEL_LED_HI;
            SW_LO_ADDR:  sel = SEL_SW_LO;
            SW_HI_ADDR:  sel = SEL_SW_HI;
            default:     sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchroniser plus a single shared debounce counter for a bus of switches.
// The whole bus must differ from the accepted value for DEBOUNCE_CYCLES consecutive
// cycles before the synchronised value is taken.
module switch_debounce #(
    parameter int          W               = 24,
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] deb
);

    // One spare bit so the counter can never wrap before reaching its terminal value.
    localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [W-1:0]     meta;
    logic [W-1:0]     sync;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous switches into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= din;
            sync <= meta;
        end
    end

    // Count cycles of disagreement; accept the new value on the terminal count.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            deb <= '0;
        end else if (sync == deb) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            deb <= sync;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/led_switch_io.sv
// IO-side responder for the CPU memory/IO router: board LED register and debounced switches.
// Optional macro IO_BUS_ERR_EN adds a sticky bus_err flag (cleared by err_clr) that flags
// accesses to unmapped addresses.
module led_switch_io
    import io_map_pkg::*;
#(
    parameter logic [19:0]          DEBOUNCE_CYCLES = 20'd500000,
    parameter logic [IO_DATA_W-1:0] LED_RESET_VAL   = 24'h000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 led_ctrl,
    input  logic                 switch_ctrl,
    input  logic [31:0]          addr,
    input  logic [IO_DATA_W-1:0] io_wdata,
    output logic [IO_DATA_W-1:0] io_rdata,
    input  logic [IO_DATA_W-1:0] switch_in,
`ifdef IO_BUS_ERR_EN
    output logic                 bus_err,
    input  logic                 err_clr,
`endif
    output logic [IO_DATA_W-1:0] led_out
);

    io_sel_e              sel;
    logic [IO_DATA_W-1:0] led_q;
    logic [IO_DATA_W-1:0] deb;

    // The high LED half only takes the low byte of the write data.
    logic unused_wdata;
    assign unused_wdata = ^io_wdata[23:16];

    assign sel     = io_decode(addr);
    assign led_out = led_q;

    switch_debounce #(
        .W               (IO_DATA_W),
        .DEBOUNCE_CYCLES (32'(DEBOUNCE_CYCLES))
    ) u_sw_deb (
        .clk  (clk),
        .rst  (rst),
        .din  (switch_in),
        .deb  (deb)
    );

    // LED register: each half written independently.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_q <= LED_RESET_VAL;
        end else if (led_ctrl) begin
            case (sel)
                SEL_LED_LO: led_q[15:0]  <= io_wdata[15:0];
                SEL_LED_HI: led_q[23:16] <= io_wdata[7:0];
                default:    ;
            endcase
        end
    end

    // Zero-latency readback from registered state, so a same-cycle write or debounce
    // update is only visible on the following cycle.
    always_comb begin
        io_rdata = '0;
        if (switch_ctrl) begin
            case (sel)
                SEL_SW_LO:  io_rdata = {8'h0,  deb[15:0]};
                SEL_SW_HI:  io_rdata = {16'h0, deb[23:16]};
                SEL_LED_LO: io_rdata = {8'h0,  led_q[15:0]};
                SEL_LED_HI: io_rdata = {16'h0, led_q[23:16]};
                default:    io_rdata = '0;
            endcase
        end
    end

`ifdef IO_BUS_ERR_EN
    // Sticky error on any access to an unmapped address; a new error beats a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_err <= 1'b0;
        end else if ((led_ctrl || switch_ctrl) && (sel == SEL_NONE)) begin
            bus_err <= 1'b1;
        end else if (err_clr) begin
            bus_err <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_led_switch_io.sv
// Self-checking bench for led_switch_io: directed scenarios followed by random traffic,
// all checked against a cycle-level behavioural model of the LED/switch block.
module tb_led_switch_io;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        led_ctrl;
    logic        switch_ctrl;
    logic [31:0] addr;
    logic [23:0] io_wdata;
    logic [23:0] io_rdata;
    logic [23:0] switch_in;
    logic [23:0] led_out;
`ifdef IO_BUS_ERR_EN
    logic        bus_err;
    logic        err_clr;
`endif

    always #5 clk = ~clk;

    led_switch_io #(
        .DEBOUNCE_CYCLES (20'(D)),
        .LED_RESET_VAL   (24'h000000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .led_ctrl    (led_ctrl),
        .switch_ctrl (switch_ctrl),
        .addr        (addr),
        .io_wdata    (io_wdata),
        .io_rdata    (io_rdata),
        .switch_in   (switch_in),
`ifdef IO_BUS_ERR_EN
        .bus_err     (bus_err),
        .err_clr     (err_clr),
`endif
        .led_out     (led_out)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Behavioural model state.
    logic [23:0] m_led;
    logic [23:0] m_deb;
    logic [23:0] m_sw_old;   // switch value sampled two edges ago
    logic [23:0] m_sw_new;   // switch value sampled one edge ago
    int          m_run;      // consecutive edges the synchronised value disagreed with m_deb
    logic        m_err;

    function automatic logic [23:0] exp_read();
        if (!switch_ctrl) return 24'h0;
        case (addr)
            32'hFFFF_FC70: return {8'h0,  m_deb[15:0]};
            32'hFFFF_FC72: return {16'h0, m_deb[23:16]};
            32'hFFFF_FC60: return {8'h0,  m_led[15:0]};
            32'hFFFF_FC62: return {16'h0, m_led[23:16]};
            default:       return 24'h0;
        endcase
    endfunction

    function automatic bit mapped(input logic [31:0] a);
        return a == 32'hFFFF_FC60 || a == 32'hFFFF_FC62 ||
               a == 32'hFFFF_FC70 || a == 32'hFFFF_FC72;
    endfunction

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic model_edge();
        logic [23:0] sync_now;
        if (rst) begin
            m_led = 24'h0; m_deb = 24'h0; m_sw_old = 24'h0; m_sw_new = 24'h0;
            m_run = 0;     m_err = 1'b0;
        end else begin
            if (led_ctrl && addr == 32'hFFFF_FC60) m_led[15:0]  = io_wdata[15:0];
            if (led_ctrl && addr == 32'hFFFF_FC62) m_led[23:16] = io_wdata[7:0];
`ifdef IO_BUS_ERR_EN
            if ((led_ctrl || switch_ctrl) && !mapped(addr)) m_err = 1'b1;
            else if (err_clr)                                m_err = 1'b0;
`endif
            sync_now = m_sw_old;
            m_sw_old = m_sw_new;
            m_sw_new = switch_in;
            if (sync_now == m_deb) m_run = 0;
            else begin
                m_run++;
                if (m_run == D) begin
                    m_deb = sync_now;
                    m_run = 0;
                end
            end
        end
    endtask

    // One cycle: check the combinational read, clock, then check registered outputs.
    task automatic step();
        #1 chk("rdata", {8'h0, io_rdata}, {8'h0, exp_read()});
        @(posedge clk);
        model_edge();
        #1;
        chk("led_out", {8'h0, led_out}, {8'h0, m_led});
`ifdef IO_BUS_ERR_EN
        chk("bus_err", {31'h0, bus_err}, {31'h0, m_err});
`endif
    endtask

    initial begin
        rst = 1'b1; led_ctrl = 1'b0; switch_ctrl = 1'b0; addr = 32'h0;
        io_wdata = 24'h0; switch_in = 24'hFFFFFF;
`ifdef IO_BUS_ERR_EN
        err_clr = 1'b0;
`endif
        m_led = 24'hX; m_deb = 24'hX; m_sw_old = 24'h0; m_sw_new = 24'h0; m_run = 0; m_err = 1'b0;

        // Reset with all switches high.
        step(); step();
        chk("rst_led", {8'h0, led_out}, 32'h0);
        chk("rst_rdata", {8'h0, io_rdata}, 32'h0);
        rst = 1'b0; switch_ctrl = 1'b1; addr = 32'hFFFF_FC70;
        repeat (5) step();
        #1 chk("rst_deb_hold", {8'h0, io_rdata}, 32'h0);
        step();
        #1 chk("rst_deb_take", {8'h0, io_rdata}, 32'h00FFFF);
        switch_in = 24'h0;
        repeat (8) step();

        // LED halves.
        switch_ctrl = 1'b0; led_ctrl = 1'b1;
        addr = 32'hFFFF_FC60; io_wdata = 24'h00A5A5; step();
        chk("led_lo", {8'h0, led_out}, 32'h0000A5A5);
        addr = 32'hFFFF_FC62; io_wdata = 24'h00003C; step();
        chk("led_hi", {8'h0, led_out}, 32'h003CA5A5);

        // Unmapped write.
        addr = 32'hFFFF_FC64; io_wdata = 24'hFFFFFF; step();
        chk("unmapped_led", {8'h0, led_out}, 32'h003CA5A5);
`ifdef IO_BUS_ERR_EN
        chk("err_set", {31'h0, bus_err}, 32'h1);
        led_ctrl = 1'b0; err_clr = 1'b1; step();
        chk("err_clr", {31'h0, bus_err}, 32'h0);
        err_clr = 1'b0; led_ctrl = 1'b1;
`endif

        // Simultaneous write and readback.
        addr = 32'hFFFF_FC62; io_wdata = 24'h0; step();
        addr = 32'hFFFF_FC60; io_wdata = 24'h000011; step();
        switch_ctrl = 1'b1; io_wdata = 24'h000022;
        #1 chk("simul_rd", {8'h0, io_rdata}, 32'h000011);
        step();
        chk("simul_wr", {8'h0, led_out}, 32'h000022);

        // Switch debounce: new value appears on the sixth edge.
        led_ctrl = 1'b0; addr = 32'hFFFF_FC70; switch_in = 24'h123456;
        repeat (5) step();
        #1 chk("sw_pre", {8'h0, io_rdata}, 32'h0);
        step();
        #1 chk("sw_lo", {8'h0, io_rdata}, 32'h003456);
        addr = 32'hFFFF_FC72;
        #1 chk("sw_hi", {8'h0, io_rdata}, 32'h000012);
        repeat (4) step();

        // Short glitch is filtered.
        switch_in = 24'hFFFFFF; repeat (3) step();
        switch_in = 24'h123456; repeat (8) step();
        #1 chk("glitch", {8'h0, io_rdata}, 32'h000012);

        // Reset in the middle of a debounce count.
        addr = 32'hFFFF_FC70; switch_in = 24'h654321;
        repeat (4) step();
        rst = 1'b1; step(); rst = 1'b0;
        #1 chk("rst_mid", {8'h0, io_rdata}, 32'h0);
        repeat (5) step();
        #1 chk("rst_mid_hold", {8'h0, io_rdata}, 32'h0);
        step();
        #1 chk("rst_mid_take", {8'h0, io_rdata}, 32'h004321);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            rst         = ($urandom_range(0, 63) == 0);
            led_ctrl    = $urandom_range(0, 1) == 1;
            switch_ctrl = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 5))
                0:       addr = 32'hFFFF_FC60;
                1:       addr = 32'hFFFF_FC62;
                2:       addr = 32'hFFFF_FC70;
                3:       addr = 32'hFFFF_FC72;
                4:       addr = 32'hFFFF_FC64;
                default: addr = $urandom();
            endcase
            io_wdata = 24'($urandom());
            if ($urandom_range(0, 9) == 0) switch_in = 24'($urandom());
`ifdef IO_BUS_ERR_EN
            err_clr = ($urandom_range(0, 3) == 0);
`endif
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
